// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared constants, FSM state type and helpers for the fill RAM
package ram_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_ADDR_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    // Number of byte lanes in a word; DATA_W is always a multiple of 8.
    function automatic int byte_lanes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/ram_sp_fill_if.sv
// rtl/ram_sp_fill_if.sv - single-port access bus between requester and RAM
interface ram_sp_fill_if
    import ram_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
);

    logic                          req;
    logic                          we;
    logic [ADDR_W-1:0]             addr;
    logic [byte_lanes(DATA_W)-1:0] be;
    logic [DATA_W-1:0]             din;
    logic                          ready;
    logic [DATA_W-1:0]             dout;
    logic                          dout_valid;

    modport master (
        output req,
        output we,
        output addr,
        output be,
        output din,
        input  ready,
        input  dout,
        input  dout_valid
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  be,
        input  din,
        output ready,
        output dout,
        output dout_valid
    );

endinterface

// File: rtl/ram_fill_ctrl.sv
// rtl/ram_fill_ctrl.sv - whole-array fill FSM and address counter
module ram_fill_ctrl
    import ram_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_value,
    output logic              idle,
    output logic              busy,
    output logic              fill_done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    // One extra counter bit keeps DEPTH-1 distinct from a wrapped 0.
    localparam logic [ADDR_W:0] LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};

    fill_state_t       state;
    fill_state_t       state_nxt;
    logic [ADDR_W:0]   cnt;
    logic [DATA_W-1:0] pattern;
    logic              last;

    assign last = (cnt == LAST_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            pattern   <= '0;
            fill_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            fill_done <= (state == FILL) && last;
            if ((state == IDLE) && fill_start) begin
                cnt     <= '0;
                pattern <= fill_value;
            end else if (state == FILL) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fill_start) state_nxt = FILL;
            FILL:    if (last)       state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_comb begin
        idle    = (state == IDLE);
        busy    = (state == FILL);
        wr_en   = (state == FILL);
        wr_addr = cnt[ADDR_W-1:0];
        wr_data = pattern;
    end

endmodule

// File: rtl/ram_sp_fill.sv
// rtl/ram_sp_fill.sv - single-port byte-enabled RAM with hardware whole-array fill
module ram_sp_fill
    import ram_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_sp_fill_if.slave      bus,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic              fill_done
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int LANES = byte_lanes(DATA_W);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              idle;
    logic              fill_we;
    logic [ADDR_W-1:0] fill_addr;
    logic [DATA_W-1:0] fill_data;
    logic              accept;
    logic              acc_wr;
    logic              acc_rd;
    logic [DATA_W-1:0] dout_q;
    logic              dout_valid_q;

    ram_fill_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fill_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .fill_start (fill_start),
        .fill_value (fill_value),
        .idle       (idle),
        .busy       (busy),
        .fill_done  (fill_done),
        .wr_en      (fill_we),
        .wr_addr    (fill_addr),
        .wr_data    (fill_data)
    );

    // A fill request wins over a coincident access in the same cycle.
    assign bus.ready = idle && !fill_start;
    assign accept    = bus.req && bus.ready;
    assign acc_wr    = accept && bus.we;
    assign acc_rd    = accept && !bus.we;

    // Array contents are deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            mem[fill_addr] <= fill_data;
        end else if (acc_wr) begin
            for (int i = 0; i < LANES; i++) begin
                if (bus.be[i]) begin
                    mem[bus.addr][8*i +: 8] <= bus.din[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= acc_rd;
            if (acc_rd) begin
                dout_q <= mem[bus.addr];
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;

endmodule

// File: tb/tb_ram_sp_fill.sv
// tb/tb_ram_sp_fill.sv - directed table-driven bench for ram_sp_fill in three configurations
module tb_ram_sp_fill;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    ram_sp_fill_if #(.DATA_W(8),  .ADDR_W(16)) bd ();
    ram_sp_fill_if #(.DATA_W(16), .ADDR_W(4))  bw ();
    ram_sp_fill_if #(.DATA_W(8),  .ADDR_W(4))  ba ();

    logic        fs_d = 1'b0, fs_w = 1'b0, fs_a = 1'b0;
    logic [7:0]  fv_d = '0, fv_a = '0;
    logic [15:0] fv_w = '0;
    logic        busy_d, busy_w, busy_a;
    logic        fd_d, fd_w, fd_a;

    ram_sp_fill #(.DATA_W(8), .ADDR_W(16)) u_def (
        .clk(clk), .rst_n(rst_n), .bus(bd), .fill_start(fs_d),
        .fill_value(fv_d), .busy(busy_d), .fill_done(fd_d));

    ram_sp_fill #(.DATA_W(16), .ADDR_W(4)) u_w16 (
        .clk(clk), .rst_n(rst_n), .bus(bw), .fill_start(fs_w),
        .fill_value(fv_w), .busy(busy_w), .fill_done(fd_w));

    ram_sp_fill #(.DATA_W(8), .ADDR_W(4)) u_a4 (
        .clk(clk), .rst_n(rst_n), .bus(ba), .fill_start(fs_a),
        .fill_value(fv_a), .busy(busy_a), .fill_done(fd_a));

    typedef struct {
        logic        rq;
        logic        w;
        logic [15:0] a;
        logic        b;
        logic [7:0]  d;
        logic [7:0]  edout;
        logic        evalid;
    } vec_t;

    vec_t tv [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic d_acc(input logic w, input logic [15:0] a, input logic b, input logic [7:0] d);
        @(negedge clk);
        bd.req = 1'b1; bd.we = w; bd.addr = a; bd.be = b; bd.din = d;
        @(posedge clk); #1;
        bd.req = 1'b0;
    endtask

    task automatic w_acc(input logic w, input logic [3:0] a, input logic [1:0] b, input logic [15:0] d);
        @(negedge clk);
        bw.req = 1'b1; bw.we = w; bw.addr = a; bw.be = b; bw.din = d;
        @(posedge clk); #1;
        bw.req = 1'b0;
    endtask

    task automatic a_acc(input logic w, input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        ba.req = 1'b1; ba.we = w; ba.addr = a; ba.be = 1'b1; ba.din = d;
        @(posedge clk); #1;
        ba.req = 1'b0;
    endtask

    // Launch a fill on the ADDR_W=4 instance and observe it with a bounded loop.
    task automatic run_fill(input logic [7:0] v, input logic with_req,
                            output int busy_n, output int rdy_bad,
                            output int done_n, output int vld_bad);
        busy_n = 0; rdy_bad = 0; done_n = 0; vld_bad = 0;
        @(negedge clk);
        fs_a = 1'b1; fv_a = v;
        ba.req = with_req; ba.we = 1'b0; ba.addr = 4'd3;
        #1;
        chk("start_ready_low", 32'(ba.ready), 32'd0);
        @(posedge clk); #1;
        fs_a = 1'b0; ba.req = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (busy_a) busy_n++;
            if (busy_a && ba.ready) rdy_bad++;
            if (fd_a) done_n++;
            if (ba.dout_valid) vld_bad++;
            // Mid-fill restart attempt and access attempt must both be ignored.
            fs_a   = (c == 8);
            fv_a   = (c == 8) ? ~v : v;
            ba.req = (c == 8);
            @(posedge clk); #1;
        end
        fs_a = 1'b0; ba.req = 1'b0;
    endtask

    initial begin
        logic [7:0] orig;
        int bn, rb, dn, vb;

        bd.req = 0; bd.we = 0; bd.addr = '0; bd.be = '0; bd.din = '0;
        bw.req = 0; bw.we = 0; bw.addr = '0; bw.be = '0; bw.din = '0;
        ba.req = 0; ba.we = 0; ba.addr = '0; ba.be = '0; ba.din = '0;

        tv[0]  = '{1'b1, 1'b1, 16'h0010, 1'b1, 8'h11, 8'h00, 1'b0};
        tv[1]  = '{1'b1, 1'b1, 16'h0011, 1'b1, 8'h22, 8'h00, 1'b0};
        tv[2]  = '{1'b1, 1'b0, 16'h0010, 1'b0, 8'h00, 8'h11, 1'b1};
        tv[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h11, 1'b0};
        tv[4]  = '{1'b1, 1'b1, 16'h0010, 1'b0, 8'h99, 8'h11, 1'b0};
        tv[5]  = '{1'b1, 1'b0, 16'h0010, 1'b0, 8'h00, 8'h11, 1'b1};
        tv[6]  = '{1'b1, 1'b0, 16'h0011, 1'b0, 8'h00, 8'h22, 1'b1};
        tv[7]  = '{1'b1, 1'b1, 16'h0000, 1'b1, 8'hA5, 8'h22, 1'b0};
        tv[8]  = '{1'b1, 1'b1, 16'h0011, 1'b1, 8'h5C, 8'h22, 1'b0};
        tv[9]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 8'hA5, 1'b1};
        tv[10] = '{1'b1, 1'b0, 16'h0011, 1'b0, 8'h00, 8'h5C, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_dout",      32'(bd.dout),       32'd0);
        chk("rst_valid",     32'(bd.dout_valid), 32'd0);
        chk("rst_busy",      32'(busy_a),        32'd0);
        chk("rst_fill_done", 32'(fd_a),          32'd0);
        chk("rst_ready",     32'(ba.ready),      32'd1);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            bd.req = tv[i].rq; bd.we = tv[i].w; bd.addr = tv[i].a;
            bd.be = tv[i].b; bd.din = tv[i].d;
            #1;
            chk($sformatf("vec%0d_ready", i), 32'(bd.ready), 32'd1);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_dout", i),  32'(bd.dout),       32'(tv[i].edout));
            chk($sformatf("vec%0d_valid", i), 32'(bd.dout_valid), 32'(tv[i].evalid));
            bd.req = 1'b0;
        end

        // Top address round trip, then put the original contents back.
        d_acc(1'b0, 16'hFFFF, 1'b0, 8'h00);
        orig = bd.dout;
        d_acc(1'b1, 16'hFFFF, 1'b1, 8'hFF);
        chk("top_wr_novalid", 32'(bd.dout_valid), 32'd0);
        d_acc(1'b0, 16'hFFFF, 1'b0, 8'h00);
        chk("top_rd_dout",  32'(bd.dout),       32'hFF);
        chk("top_rd_valid", 32'(bd.dout_valid), 32'd1);
        @(posedge clk); #1;
        chk("top_valid_pulse", 32'(bd.dout_valid), 32'd0);
        d_acc(1'b1, 16'hFFFF, 1'b1, orig);

        w_acc(1'b1, 4'd5, 2'b11, 16'hABCD);
        w_acc(1'b1, 4'd5, 2'b10, 16'h1200);
        w_acc(1'b0, 4'd5, 2'b00, 16'h0000);
        chk("w16_be_hi", 32'(bw.dout), 32'h12CD);
        chk("w16_valid", 32'(bw.dout_valid), 32'd1);
        w_acc(1'b1, 4'd5, 2'b01, 16'hFF77);
        w_acc(1'b0, 4'd5, 2'b00, 16'h0000);
        chk("w16_be_lo", 32'(bw.dout), 32'h1277);

        run_fill(8'h5A, 1'b0, bn, rb, dn, vb);
        chk("fill_busy_cycles", 32'(bn), 32'd16);
        chk("fill_ready_busy",  32'(rb), 32'd0);
        chk("fill_done_pulses", 32'(dn), 32'd1);
        chk("fill_no_valid",    32'(vb), 32'd0);
        for (int a = 0; a < 16; a++) begin
            a_acc(1'b0, 4'(a), 8'h00);
            chk($sformatf("fill5a_rd%0d", a), 32'(ba.dout), 32'h5A);
        end

        run_fill(8'h00, 1'b1, bn, rb, dn, vb);
        chk("coinc_busy_cycles", 32'(bn), 32'd16);
        chk("coinc_no_valid",    32'(vb), 32'd0);
        chk("coinc_done_pulses", 32'(dn), 32'd1);
        chk("coinc_dout_held",   32'(ba.dout), 32'h5A);

        @(negedge clk);
        fs_a = 1'b1; fv_a = 8'h5A;
        @(posedge clk); #1;
        fs_a = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy",  32'(busy_a),        32'd0);
        chk("midrst_dout",  32'(ba.dout),       32'd0);
        chk("midrst_ready", 32'(ba.ready),      32'd1);
        chk("midrst_valid", 32'(ba.dout_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 16; a++) begin
            a_acc(1'b0, 4'(a), 8'h00);
            chk($sformatf("midrst_rd%0d", a), 32'(ba.dout), (a < 7) ? 32'h5A : 32'h00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ram_sp_fill.md
RAM_SP_FILL -- requirements
Module: ram_sp_fill

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, data word width in bits; it shall be a multiple of 8.
REQ-002 SHALL provide parameter ADDR_W, default 16, address width; DEPTH = 2**ADDR_W words (default 8x64k).
REQ-003 SHALL provide port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL provide port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL provide port req  input  1  access request, sampled at the clk edge.
REQ-006 SHALL provide port we  input  1  1 = write, 0 = read; qualifies req.
REQ-007 SHALL provide port addr  input  ADDR_W  word address.
REQ-008 SHALL provide port be  input  DATA_W/8  byte-lane write enables; bit i covers din[8i+7:8i].
REQ-009 SHALL provide port din  input  DATA_W  write data.
REQ-010 SHALL provide port ready  output  1  request acceptance qualifier (combinational).
REQ-011 SHALL provide port dout  output  DATA_W  registered read data.
REQ-012 SHALL provide port dout_valid  output  1  one-cycle pulse marking new dout.
REQ-013 SHALL provide port fill_start  input  1  starts a whole-array fill.
REQ-014 SHALL provide port fill_value  input  DATA_W  fill pattern, captured at start.
REQ-015 SHALL provide port busy  output  1  high while a fill is in progress.
REQ-016 SHALL provide port fill_done  output  1  one-cycle pulse at fill completion.

Function
REQ-017 SHALL accept an access only on an edge where req=1 and ready=1; ready = (state==IDLE) and not fill_start.
REQ-018 SHALL, on an accepted write, update exactly the byte lanes with be[i]=1 at that edge; be=0 shall leave the word unchanged.
REQ-019 SHALL, on an accepted read at edge N, present mem[addr] on dout at edge N and assert dout_valid for the cycle following edge N (1-cycle latency).
REQ-020 SHALL hold dout unchanged on writes, idle cycles and throughout fills (no write-through).
REQ-021 SHALL implement FSM IDLE and FILL: IDLE->FILL on fill_start; FILL->IDLE after writing address DEPTH-1.
REQ-022 SHALL, on entering FILL, capture fill_value and clear the fill counter to 0; each FILL cycle writes the full word at the counter address, then increments it.
REQ-023 SHALL complete a fill in exactly DEPTH cycles, with busy=1 for those DEPTH cycles and fill_done=1 in the cycle after the last write.
REQ-024 SHALL ignore fill_start while in FILL and ignore req (ready=0) for the whole fill.
REQ-025 SHALL give fill_start priority when fill_start and req coincide in IDLE; the req is not accepted.
REQ-026 SHALL compute the fill counter in ADDR_W+1 bits so that the terminal address DEPTH-1 is detected without wrap-around aliasing.

Reset
REQ-027 SHALL, on rst_n=0, immediately force state=IDLE, dout=0, dout_valid=0, busy=0, fill_done=0 and the fill counter to 0.
REQ-028 SHALL NOT reset array contents; a reset during a fill leaves already-written words filled and the remaining words unchanged.

Structure
REQ-029 SHALL place the FSM state enumeration and the default DATA_W/ADDR_W constants in shared package ram_pkg.
REQ-030 SHALL implement the fill FSM and counter in one sub-module ram_fill_ctrl; the array, byte-lane write and read register stay in the top level.

Verification
REQ-031 SHALL cover (defaults): write 0xFF to 65535, read 65535 -> dout=0xFF with dout_valid one cycle after acceptance; restore the original value.
REQ-032 SHALL cover (DATA_W=16): write 0xABCD be=11 to addr 5, then 0x1200 be=10, read addr 5 -> 0x12CD.
REQ-033 SHALL cover (ADDR_W=4): fill_start with fill_value=0x5A -> busy for 16 cycles, ready=0 throughout, one fill_done pulse, all 16 reads -> 0x5A.
REQ-034 SHALL cover: fill_start and read req in the same IDLE cycle -> ready=0 that cycle, no dout_valid pulse, and the fill proceeds.
REQ-035 SHALL cover (ADDR_W=4, array preloaded 0x00): rst_n low after 7 fill writes -> busy=0, dout=0, ready=1; addrs 0..6 read 0x5A, addrs 7..15 read 0x00.
